sdiv32x16: RTL
==============

# sdiv32x16

Sequential signed divider, the inverse datapath of the team's 16x16 signed multiplier. It divides a 32-bit two's-complement dividend by a 16-bit two's-complement divisor. It returns a 16-bit quotient truncated toward zero and a 16-bit remainder. It uses one restoring iteration per clock and valid/ready handshakes on both sides, and sits downstream of the multiplier in DSP chains (normalisation, gain recovery, scaling).

## Interface
- No parameters; widths fixed at 32/16.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands; high only in IDLE.
- dividend  in  32  signed dividend, sampled on acceptance.
- divisor  in  16  signed divisor, sampled on acceptance.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- quotient  out  16  signed quotient.
- remainder  out  16  signed remainder.
- ovf  out  1  quotient did not fit in 16 bits; quotient is saturated.
- dbz  out  1  divisor was zero.

## Operation
- States: IDLE, DIV, FIX, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture |dividend| (33-bit-safe, so -2^31 becomes 2^31) and |divisor|, plus the sign of the quotient (dividend[31]^divisor[15]) and the sign of the remainder (dividend[31]).
  - If divisor==0, go directly to DONE. Otherwise go to DIV with the iteration counter at 31.
- DIV:
  - Each cycle: shift the partial remainder left by 1, bringing in the next dividend magnitude bit (MSB first).
  - If partial remainder >= |divisor|, subtract it and shift in quotient bit 1; otherwise shift in 0.
  - Partial remainder register is 17 bits. The 32-bit magnitude quotient register is unsigned.
  - After iteration 0 (32 cycles total), go to FIX.
- FIX:
  - Apply signs: quotient negated if the quotient sign is 1; remainder negated if the dividend was negative.
  - Overflow is set when either:
    - the quotient sign is 0 and magnitude > 32767, or
    - the quotient sign is 1 and magnitude > 32768.
  - On overflow: quotient = 16'h7FFF if the quotient sign is 0, 16'h8000 if it is 1; remainder = 0; ovf=1.
  - Go to DONE.
- Divide by zero: quotient = 16'h7FFF if dividend>=0, else 16'h8000; remainder = dividend[15:0]; dbz=1; ovf=0.
- DONE: out_valid=1. Outputs are stable while out_ready=0. On out_ready, go to IDLE and clear out_valid.
- Result identity when no ovf/dbz: dividend == quotient*divisor + remainder, with |remainder| < |divisor| and the remainder either zero or matching the dividend's sign.
- in_valid outside IDLE is ignored; operands are not queued.

## Timing
- Acceptance = rising edge where in_valid & in_ready (call this cycle 0).
- Normal latency: DIV occupies cycles 1-32 and FIX cycle 33. out_valid is high from cycle 34.
- dbz latency: out_valid is high from cycle 1.
- Back-to-back: in_ready rises the cycle after the out_valid&out_ready edge. Minimum issue interval is 35 cycles.
- Reset, including mid-DIV/FIX/DONE: next state is IDLE with out_valid=0, quotient=0, remainder=0, ovf=0, dbz=0, and all internal registers cleared. in_ready=1 the cycle after reset deasserts. A result in flight is discarded.
- No combinational path from in_valid/dividend/divisor to any output. in_ready and out_valid are decoded from registered state only.

## Test plan
- 100 / 7 -> q=14, r=2. Then -100 / 7 -> q=-14, r=-2. Then 100 / -7 -> q=-14, r=2. Then -100 / -7 -> q=14, r=-2. Each has out_valid exactly 34 cycles after acceptance and ovf=dbz=0.
- Range edges:
  - 32'hFFFF8000 / 1 -> q=16'h8000, r=0, ovf=0.
  - 32'h00007FFF / 1 -> q=16'h7FFF, ovf=0.
  - 32'h00008000 / 1 -> q=16'h7FFF, r=0, ovf=1.
  - 32'h80000000 / 16'h8000 -> q=16'h7FFF, ovf=1.
- 12345 / 0 -> dbz=1, q=16'h7FFF, r=16'h3039, out_valid 1 cycle after acceptance. Then -5 / 0 -> q=16'h8000, r=16'hFFFB.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable and in_ready stays 0 while in_valid is toggling. After out_ready pulses, in_ready=1 the next cycle.
- Reset mid-operation: assert rst at cycle 15 of a division. Next cycle out_valid=0 and outputs are 0. Then issue 1000 / 3 -> q=333, r=1 with normal 34-cycle latency.
- Random: 10k random operand pairs, divisor != 0, checked against a truncating reference model and the result identity above, with random out_ready stalls.

Source files
------------

// File: rtl/sdiv32x16_if.sv
// rtl/sdiv32x16_if.sv - operand/result handshake bundle for the 32/16 signed divider
interface sdiv32x16_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] dividend;
   logic [15:0] divisor;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        ovf;
   logic        dbz;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, ovf, dbz
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, ovf, dbz
   );
endinterface

// File: rtl/sdiv32x16.sv
// rtl/sdiv32x16.sv - sequential restoring signed divider, 32-bit dividend by 16-bit divisor
module sdiv32x16 (
   input  logic         clk,
   input  logic         rst,
   sdiv32x16_if.slave   bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] dvd_q, dvd_d;     // dividend magnitude, shifted out MSB first
   logic [15:0] dvs_q, dvs_d;     // divisor magnitude (32768 fits unsigned)
   logic [16:0] rem_q, rem_d;     // partial remainder
   logic [31:0] quo_q, quo_d;     // unsigned magnitude quotient
   logic        qsign_q, qsign_d;
   logic        rsign_q, rsign_d;
   logic [15:0] quot_q, quot_d;
   logic [15:0] rmd_q, rmd_d;
   logic        ovf_q, ovf_d;
   logic        dbz_q, dbz_d;

   logic [31:0] abs_dividend;
   logic [15:0] abs_divisor;
   logic [16:0] shifted;
   logic [16:0] trial;
   logic        fits;
   logic        mag_ovf;

   // Operand magnitudes; -2^31 maps to 32'h8000_0000 read as unsigned.
   always_comb begin
      abs_dividend = bus.dividend[31] ? (~bus.dividend + 32'd1) : bus.dividend;
      abs_divisor  = bus.divisor[15]  ? (~bus.divisor + 16'd1)  : bus.divisor;
   end

   // One restoring step: shift in next dividend bit, trial-subtract the divisor.
   always_comb begin
      shifted = {rem_q[15:0], dvd_q[31]};
      fits    = (shifted >= {1'b0, dvs_q});
      trial   = shifted - {1'b0, dvs_q};
      mag_ovf = qsign_q ? (quo_q > 32'd32768) : (quo_q > 32'd32767);
   end

   // Next-state and datapath control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      qsign_d = qsign_q;
      rsign_d = rsign_q;
      quot_d  = quot_q;
      rmd_d   = rmd_q;
      ovf_d   = ovf_q;
      dbz_d   = dbz_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               if (bus.divisor == 16'd0) begin
                  // Divide by zero saturates toward the dividend's sign.
                  quot_d  = bus.dividend[31] ? 16'h8000 : 16'h7FFF;
                  rmd_d   = bus.dividend[15:0];
                  dbz_d   = 1'b1;
                  ovf_d   = 1'b0;
                  state_d = S_DONE;
               end else begin
                  dvd_d   = abs_dividend;
                  dvs_d   = abs_divisor;
                  qsign_d = bus.dividend[31] ^ bus.divisor[15];
                  rsign_d = bus.dividend[31];
                  rem_d   = 17'd0;
                  quo_d   = 32'd0;
                  cnt_d   = 5'd31;
                  state_d = S_DIV;
               end
            end
         end
         S_DIV: begin
            dvd_d = {dvd_q[30:0], 1'b0};
            rem_d = fits ? trial : shifted;
            quo_d = {quo_q[30:0], fits};
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd0) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            dbz_d = 1'b0;
            if (mag_ovf) begin
               quot_d = qsign_q ? 16'h8000 : 16'h7FFF;
               rmd_d  = 16'd0;
               ovf_d  = 1'b1;
            end else begin
               // Negating 32768 wraps to 16'h8000, which is the wanted -32768.
               quot_d = qsign_q ? (~quo_q[15:0] + 16'd1) : quo_q[15:0];
               rmd_d  = rsign_q ? (~rem_q[15:0] + 16'd1) : rem_q[15:0];
               ovf_d  = 1'b0;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any result in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 5'd0;
         dvd_q   <= 32'd0;
         dvs_q   <= 16'd0;
         rem_q   <= 17'd0;
         quo_q   <= 32'd0;
         qsign_q <= 1'b0;
         rsign_q <= 1'b0;
         quot_q  <= 16'd0;
         rmd_q   <= 16'd0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         qsign_q <= qsign_d;
         rsign_q <= rsign_d;
         quot_q  <= quot_d;
         rmd_q   <= rmd_d;
         ovf_q   <= ovf_d;
         dbz_q   <= dbz_d;
      end
   end

   // Handshake flags decode from registered state only.
   always_comb begin
      bus.in_ready  = (state_q == S_IDLE);
      bus.out_valid = (state_q == S_DONE);
      bus.quotient  = quot_q;
      bus.remainder = rmd_q;
      bus.ovf       = ovf_q;
      bus.dbz       = dbz_q;
   end

endmodule
